llc_cmd_dispatcher: RTL and testbench
=====================================

# llc_cmd_dispatcher

Buffers trace commands (code plus address) arriving from the trace front end and issues them, in order and one at a time, to the last-level cache. Each command is presented on stable `llc_cmd`/`llc_addr` lines, framed by a single-cycle `llc_strobe`; the cache acts on the rising edge of that strobe. The block sits directly upstream of the LLC and replaces the free-running eof toggle with a flow-controlled handshake. It also drops illegal command codes and optionally keeps per-class command counts.

## Interface
- CMDSIZE, 4, width of the command code
- ADDR_BITS, 32, width of the address
- DEPTH, 4, FIFO entries; must be a power of two, ≥2

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream command valid
- in_ready  out  1  dispatcher can accept a command
- in_cmd  in  CMDSIZE  command code
- in_addr  in  ADDR_BITS  command address
- llc_strobe  out  1  single-cycle issue pulse to the LLC (drives its eof)
- llc_cmd  out  CMDSIZE  issued command code
- llc_addr  out  ADDR_BITS  issued address
- llc_busy  in  1  LLC still processing; blocks the next issue
- idle  out  1  FIFO empty and FSM in IDLE
- drop_cnt  out  16  count of dropped illegal commands; saturates at 16'hFFFF
- rd_cnt, wr_cnt, snp_cnt, ctl_cnt  out  32 each  per-class issue counters (see Configuration)

## Operation
- Legal codes: 0–6, 8 and 9. Codes 7 and 10–15 are illegal.
- Enqueue occurs when `in_valid && in_ready`. `in_ready = !full`.
- An illegal code is accepted (handshake completes) but is not stored, and `drop_cnt` increments.
- Codes 8 (clear) and 9 (print) are ordinary entries. They issue in order like any other command; they are not flushes and are not reordered.
- The FIFO is a circular buffer. Read and write pointers are log2(DEPTH)+1 bits wide and wrap modulo 2·DEPTH.
  - full: pointers differ only in the MSB.
  - empty: pointers are equal.
- FSM states and transitions:
  - IDLE → ISSUE when the FIFO is non-empty and `llc_busy` is 0. On entry, the head entry is popped and registered into `llc_cmd`/`llc_addr`.
  - ISSUE: `llc_strobe` = 1 for exactly this cycle. Next state is GAP.
  - GAP: `llc_strobe` = 0. Stays in GAP while `llc_busy` = 1. When `llc_busy` = 0, returns to IDLE; the minimum stay is one cycle.
- `llc_cmd`/`llc_addr` hold their value from ISSUE until the next entry into ISSUE.
- Simultaneous enqueue and pop:
  - Both take effect in the same cycle; the occupancy count is unchanged.
  - When full, `in_ready` = 0 in that cycle. There is no bypass.
- Enqueue into an empty FIFO while in IDLE: the entry is not visible to the pop until the next cycle.

## Timing
- Reset values (asserted asynchronously and immediately):
  - state IDLE, FIFO empty (pointers 0)
  - `llc_strobe` = 0, `llc_cmd` = 0, `llc_addr` = 0
  - `in_ready` = 1, `idle` = 1
  - all counters 0
- Reset mid-issue truncates the strobe at once and discards all queued entries.
- Latency with the FIFO empty, the FSM in IDLE and `llc_busy` = 0:
  - command accepted at edge N
  - ISSUE state entered at edge N+2
  - `llc_strobe` high during the cycle after N+2
- Back-to-back issue period is a minimum of 3 cycles (IDLE, ISSUE, GAP) when `llc_busy` stays 0.
- `llc_busy` is sampled only in IDLE and GAP; its value during ISSUE is ignored.
- All outputs are registered except `in_ready` and `idle`, which are decoded from registered state.

## Configuration
- Macro: `LLC_DISPATCH_COUNT_EN`.
- Defined: each counter increments by 1 in the cycle the FSM enters ISSUE, according to the issued code.
  - `rd_cnt`: codes 0 and 2
  - `wr_cnt`: code 1
  - `snp_cnt`: codes 3–6
  - `ctl_cnt`: codes 8 and 9
  - Counters are 32-bit and wrap.
- Undefined: the counter logic is absent and all four outputs are tied to 0. `drop_cnt` is always present.

## Test plan
- Reset, then push cmd 0 addr 32'h1000_0040 with `llc_busy` = 0:
  - exactly one `llc_strobe` pulse, 2 cycles after acceptance
  - `llc_cmd` = 0, `llc_addr` = 32'h1000_0040
  - `rd_cnt` = 1
- Push DEPTH+1 commands back-to-back with `llc_busy` held at 1:
  - `in_ready` falls once 4 entries are stored
  - after `llc_busy` releases, all commands issue in push order, 3 cycles apart
- Push code 7, then code 12, then cmd 1 addr 32'hABCD_0001:
  - `drop_cnt` = 2
  - only cmd 1 is issued; `wr_cnt` = 1
- Hold `llc_busy` = 1 for 5 cycles after an issue:
  - FSM stays in GAP
  - the next strobe comes no earlier than 1 cycle after `llc_busy` falls
  - `llc_addr` is unchanged throughout
- Assert `rst_n` = 0 mid-ISSUE with 3 entries queued:
  - `llc_strobe` drops immediately
  - after release: `idle` = 1, no further strobes, counters 0
- Push 10 commands with enqueue and pop in the same cycle while full, 2·DEPTH pointer wrap included:
  - issued order and values match the push order exactly

Source files
------------

// File: rtl/llc_cmd_dispatcher.sv
// In-order, flow-controlled command issue to the LLC with illegal-code filtering.
// Optional per-class issue counters are built when LLC_DISPATCH_COUNT_EN is defined.
module llc_cmd_dispatcher #(
  parameter int CMDSIZE   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [CMDSIZE-1:0]   in_cmd,
  input  logic [ADDR_BITS-1:0] in_addr,
  output logic                 llc_strobe,
  output logic [CMDSIZE-1:0]   llc_cmd,
  output logic [ADDR_BITS-1:0] llc_addr,
  input  logic                 llc_busy,
  output logic                 idle,
  output logic [15:0]          drop_cnt,
  output logic [31:0]          rd_cnt,
  output logic [31:0]          wr_cnt,
  output logic [31:0]          snp_cnt,
  output logic [31:0]          ctl_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

  state_t                 state, state_nx;
  logic [CMDSIZE-1:0]     cmd_mem  [DEPTH];
  logic [ADDR_BITS-1:0]   addr_mem [DEPTH];
  logic [AW:0]            wr_ptr, rd_ptr, wr_ptr_vis;
  logic                   full, empty, head_avail;
  logic                   cmd_legal, accept, push, drop, pop;
  logic [CMDSIZE-1:0]     head_cmd;

  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  // Read side compares against a one-cycle-delayed write pointer, so a fresh
  // entry becomes poppable only on the cycle after it was written.
  assign head_avail = (wr_ptr_vis != rd_ptr);
  assign head_cmd   = cmd_mem[rd_ptr[AW-1:0]];

  assign in_ready = !full;
  assign idle     = empty && (state == IDLE);

  assign cmd_legal = (in_cmd <= CMDSIZE'(6)) || (in_cmd == CMDSIZE'(8)) || (in_cmd == CMDSIZE'(9));
  assign accept    = in_valid && in_ready;
  assign push      = accept && cmd_legal;
  assign drop      = accept && !cmd_legal;

  always_ff @(posedge clk) begin
    if (push) begin
      cmd_mem[wr_ptr[AW-1:0]]  <= in_cmd;
      addr_mem[wr_ptr[AW-1:0]] <= in_addr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      wr_ptr_vis <= '0;
      rd_ptr     <= '0;
    end else begin
      wr_ptr_vis <= wr_ptr;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (head_avail && !llc_busy) state_nx = ISSUE;
      ISSUE:   state_nx = GAP;
      GAP:     if (!llc_busy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    pop = 1'b0;
    if (state == IDLE && head_avail && !llc_busy) pop = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      llc_strobe <= 1'b0;
      llc_cmd    <= '0;
      llc_addr   <= '0;
      drop_cnt   <= '0;
    end else begin
      llc_strobe <= pop;
      if (pop) begin
        llc_cmd  <= head_cmd;
        llc_addr <= addr_mem[rd_ptr[AW-1:0]];
      end
      if (drop && drop_cnt != '1) drop_cnt <= drop_cnt + 16'd1;
    end
  end

`ifdef LLC_DISPATCH_COUNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt  <= '0;
      wr_cnt  <= '0;
      snp_cnt <= '0;
      ctl_cnt <= '0;
    end else if (pop) begin
      if (head_cmd == CMDSIZE'(0) || head_cmd == CMDSIZE'(2))
        rd_cnt <= rd_cnt + 32'd1;
      else if (head_cmd == CMDSIZE'(1))
        wr_cnt <= wr_cnt + 32'd1;
      else if (head_cmd >= CMDSIZE'(3) && head_cmd <= CMDSIZE'(6))
        snp_cnt <= snp_cnt + 32'd1;
      else
        ctl_cnt <= ctl_cnt + 32'd1;
    end
  end
`else
  assign rd_cnt  = '0;
  assign wr_cnt  = '0;
  assign snp_cnt = '0;
  assign ctl_cnt = '0;
`endif

endmodule

// File: tb/tb_llc_cmd_dispatcher.sv
// Self-checking bench for llc_cmd_dispatcher: code table, directed corner
// sequences and a random phase, all checked against a queue-based model.
module tb_llc_cmd_dispatcher;

  localparam int DEPTH = 4;
`ifdef LLC_DISPATCH_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [3:0]  in_cmd;
  logic [31:0] in_addr;
  logic        llc_strobe;
  logic [3:0]  llc_cmd;
  logic [31:0] llc_addr;
  logic        llc_busy;
  logic        idle;
  logic [15:0] drop_cnt;
  logic [31:0] rd_cnt, wr_cnt, snp_cnt, ctl_cnt;

  llc_cmd_dispatcher #(.CMDSIZE(4), .ADDR_BITS(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_addr(in_addr), .llc_strobe(llc_strobe),
    .llc_cmd(llc_cmd), .llc_addr(llc_addr), .llc_busy(llc_busy), .idle(idle),
    .drop_cnt(drop_cnt), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt),
    .snp_cnt(snp_cnt), .ctl_cnt(ctl_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
  } ent_t;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] addr;
    int          exp_issue;
    int          exp_cls;
  } vec_t;

  ent_t exp_q[$];
  ent_t mon_e;
  int   m_drop;
  int   m_cnt[4];
  int   pass_n = 0;
  int   tot_n  = 0;
  int   cyc    = 0;
  int   strobes = 0;
  int   last_sc = -100;
  int   strobe_cycs[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Class of a code: 0 rd, 1 wr, 2 snoop, 3 control, 4 illegal
  function automatic int cls_of(input logic [3:0] c);
    if (c == 4'd0 || c == 4'd2) return 0;
    if (c == 4'd1) return 1;
    if (c >= 4'd3 && c <= 4'd6) return 2;
    if (c == 4'd8 || c == 4'd9) return 3;
    return 4;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic check_counters();
    chk("rd_cnt",  rd_cnt,  CNT_EN ? 32'(m_cnt[0]) : 32'd0);
    chk("wr_cnt",  wr_cnt,  CNT_EN ? 32'(m_cnt[1]) : 32'd0);
    chk("snp_cnt", snp_cnt, CNT_EN ? 32'(m_cnt[2]) : 32'd0);
    chk("ctl_cnt", ctl_cnt, CNT_EN ? 32'(m_cnt[3]) : 32'd0);
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && llc_strobe === 1'b1) begin
      strobes++;
      chk("strobe_spacing", (cyc - last_sc) >= 3, 1);
      last_sc = cyc;
      strobe_cycs.push_back(cyc);
      chk("strobe_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("issue_cmd",  llc_cmd,  mon_e.cmd);
        chk("issue_addr", llc_addr, mon_e.addr);
        if (cls_of(mon_e.cmd) < 4) m_cnt[cls_of(mon_e.cmd)]++;
        check_counters();
      end
    end
  end

  task automatic model_accept(input logic [3:0] c, input logic [31:0] a);
    ent_t e;
    if (cls_of(c) < 4) begin
      e.cmd = c; e.addr = a;
      exp_q.push_back(e);
    end else if (m_drop < 65535) begin
      m_drop++;
    end
  endtask

  // Called at posedge+1; returns after the next posedge+1.
  task automatic drive_cycle(input logic v, input logic [3:0] c, input logic [31:0] a,
                             output logic acc);
    in_valid = v; in_cmd = c; in_addr = a;
    acc = v && in_ready;
    @(posedge clk);
    if (acc) model_accept(c, a);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic push(input logic [3:0] c, input logic [31:0] a, output int acc_cyc);
    logic acc;
    acc = 1'b0;
    acc_cyc = -1;
    for (int i = 0; i < 200 && !acc; i++) begin
      drive_cycle(1'b1, c, a, acc);
      if (acc) acc_cyc = cyc;
    end
    chk("push_accepted", acc, 1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (idle !== 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_idle", idle, 1);
    chk("drain_model_empty", exp_q.size(), 0);
  endtask

  task automatic wait_strobe();
    int n;
    n = 0;
    while (llc_strobe !== 1'b1 && n < 50) begin
      @(posedge clk); #1; n++;
    end
    chk("strobe_seen", llc_strobe, 1);
  endtask

  task automatic clear_model();
    exp_q.delete();
    m_drop = 0;
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    last_sc = -100;
  endtask

  task automatic check_reset_vals();
    chk("rst_strobe",   llc_strobe, 0);
    chk("rst_cmd",      llc_cmd,    0);
    chk("rst_addr",     llc_addr,   0);
    chk("rst_in_ready", in_ready,   1);
    chk("rst_idle",     idle,       1);
    chk("rst_drop",     drop_cnt,   0);
    check_counters();
  endtask

  task automatic reset_dut();
    in_valid = 1'b0;
    llc_busy = 1'b0;
    rst_n = 1'b0;
    clear_model();
    #1;
    check_reset_vals();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  vec_t vecs[16];

  initial begin
    int   acc_cyc, s0, rel, exp_drop;
    int   tcnt[4];
    logic acc;
    logic [3:0] wrap_cmds[10];

    // Code table: expected issue (1) or drop (0), and counter class.
    vecs[0]  = '{4'd0,  32'h0000_0100, 1, 0};
    vecs[1]  = '{4'd1,  32'h0000_0104, 1, 1};
    vecs[2]  = '{4'd2,  32'h0000_0108, 1, 0};
    vecs[3]  = '{4'd3,  32'h0000_010C, 1, 2};
    vecs[4]  = '{4'd4,  32'h0000_0110, 1, 2};
    vecs[5]  = '{4'd5,  32'h0000_0114, 1, 2};
    vecs[6]  = '{4'd6,  32'h0000_0118, 1, 2};
    vecs[7]  = '{4'd7,  32'h0000_011C, 0, 4};
    vecs[8]  = '{4'd8,  32'h0000_0120, 1, 3};
    vecs[9]  = '{4'd9,  32'h0000_0124, 1, 3};
    vecs[10] = '{4'd10, 32'h0000_0128, 0, 4};
    vecs[11] = '{4'd11, 32'h0000_012C, 0, 4};
    vecs[12] = '{4'd12, 32'h0000_0130, 0, 4};
    vecs[13] = '{4'd13, 32'h0000_0134, 0, 4};
    vecs[14] = '{4'd14, 32'h0000_0138, 0, 4};
    vecs[15] = '{4'd15, 32'h0000_013C, 0, 4};

    in_valid = 1'b0; in_cmd = '0; in_addr = '0; llc_busy = 1'b0; rst_n = 1'b0;
    clear_model();
    #12;
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single command latency: accepted at N, strobe during cycle after N+2.
    s0 = strobes;
    push(4'd0, 32'h1000_0040, acc_cyc);
    drain();
    chk("lat_strobe_count", strobes - s0, 1);
    chk("lat_cycles", last_sc - acc_cyc, 2);
    chk("lat_cmd", llc_cmd, 0);
    chk("lat_addr", llc_addr, 32'h1000_0040);
    chk("lat_rd_cnt", rd_cnt, CNT_EN ? 32'd1 : 32'd0);

    // Fill with busy held, then release: in order, 3 cycles apart.
    reset_dut();
    llc_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_ready_before", in_ready, 1);
      push(4'(i + 1), 32'h2000_0000 + 32'(i * 4), acc_cyc);
    end
    chk("fill_ready_full", in_ready, 0);
    chk("fill_not_idle", idle, 0);
    strobe_cycs.delete();
    fork
      begin repeat (4) @(posedge clk); #1; llc_busy = 1'b0; end
    join_none
    push(4'd8, 32'h2000_0010, acc_cyc);
    drain();
    chk("fill_issue_count", strobe_cycs.size(), DEPTH + 1);
    for (int i = 1; i < strobe_cycs.size(); i++)
      chk("fill_period", strobe_cycs[i] - strobe_cycs[i-1], 3);

    // Illegal codes are accepted but dropped.
    reset_dut();
    s0 = strobes;
    push(4'd7, 32'h7777_0000, acc_cyc);
    push(4'd12, 32'hCCCC_0000, acc_cyc);
    push(4'd1, 32'hABCD_0001, acc_cyc);
    drain();
    chk("drop_cnt_two", drop_cnt, 2);
    chk("drop_issue_count", strobes - s0, 1);
    chk("drop_last_addr", llc_addr, 32'hABCD_0001);
    chk("drop_wr_cnt", wr_cnt, CNT_EN ? 32'd1 : 32'd0);

    // Busy held after an issue: stays in GAP, address stable.
    push(4'd5, 32'h5555_0000, acc_cyc);
    wait_strobe();
    llc_busy = 1'b1;
    push(4'd6, 32'h6666_0000, acc_cyc);
    s0 = strobes;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("gap_addr_hold", llc_addr, 32'h5555_0000);
      chk("gap_no_strobe", strobes - s0, 0);
    end
    llc_busy = 1'b0;
    rel = cyc;
    for (int n = 0; n < 20 && strobes == s0; n++) begin @(posedge clk); #1; end
    chk("gap_release_strobe", strobes - s0, 1);
    chk("gap_release_delay", last_sc - rel, 2);
    drain();

    // Reset in the middle of ISSUE with entries still queued.
    reset_dut();
    llc_busy = 1'b1;
    for (int i = 0; i < DEPTH; i++) push(4'(i), 32'h4000_0000 + 32'(i), acc_cyc);
    llc_busy = 1'b0;
    wait_strobe();
    #1;
    rst_n = 1'b0;
    clear_model();
    #1;
    chk("midrst_strobe", llc_strobe, 0);
    chk("midrst_idle", idle, 1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    s0 = strobes;
    repeat (20) @(posedge clk);
    #1;
    chk("midrst_no_strobes", strobes - s0, 0);
    chk("midrst_idle_after", idle, 1);
    chk("midrst_drop", drop_cnt, 0);
    check_counters();

    // Ten pushes through the full FIFO, crossing the pointer wrap.
    wrap_cmds = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd0};
    s0 = strobes;
    for (int i = 0; i < 10; i++) push(wrap_cmds[i], $urandom, acc_cyc);
    drain();
    chk("wrap_issue_count", strobes - s0, 10);

    // Code table, one command at a time.
    reset_dut();
    exp_drop = 0;
    for (int i = 0; i < 4; i++) tcnt[i] = 0;
    for (int i = 0; i < 16; i++) begin
      s0 = strobes;
      push(vecs[i].cmd, vecs[i].addr, acc_cyc);
      drain();
      if (vecs[i].exp_issue == 0) exp_drop++;
      if (vecs[i].exp_cls < 4) tcnt[vecs[i].exp_cls]++;
      chk("tbl_issue", strobes - s0, vecs[i].exp_issue);
      chk("tbl_drop", drop_cnt, exp_drop);
      chk("tbl_rd",  rd_cnt,  CNT_EN ? 32'(tcnt[0]) : 32'd0);
      chk("tbl_wr",  wr_cnt,  CNT_EN ? 32'(tcnt[1]) : 32'd0);
      chk("tbl_snp", snp_cnt, CNT_EN ? 32'(tcnt[2]) : 32'd0);
      chk("tbl_ctl", ctl_cnt, CNT_EN ? 32'(tcnt[3]) : 32'd0);
    end

    // Random traffic with random busy.
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      llc_busy = ($urandom_range(0, 3) == 0);
      drive_cycle(1'($urandom_range(0, 1)), 4'($urandom), $urandom, acc);
    end
    llc_busy = 1'b0;
    drain();
    chk("rand_drop", drop_cnt, 16'(m_drop));
    check_counters();

    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
